// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the write-back L1 data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    DONE
  } state_e;

  // Byte-offset width of a block: word select bits plus the two byte bits.
  function automatic int unsigned off_w(input int unsigned words_per_block);
    return $clog2(words_per_block) + 2;
  endfunction

  // Line-index width.
  function automatic int unsigned ix_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Tag width: whatever is left of the 32-bit address above index and offset.
  function automatic int unsigned tag_w(input int unsigned lines,
                                        input int unsigned words_per_block);
    return 32 - off_w(words_per_block) - ix_w(lines);
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag, valid and dirty state per line; combinational lookup, synchronous update.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int unsigned LINES           = 8,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [ix_w(LINES)-1:0]                   lk_index,
  input  logic [tag_w(LINES, WORDS_PER_BLOCK)-1:0] lk_tag,
  output logic                                     hit,
  output logic                                     victim_valid,
  output logic                                     victim_dirty,
  output logic [tag_w(LINES, WORDS_PER_BLOCK)-1:0] victim_tag,
  input  logic                                     fill_en,
  input  logic [tag_w(LINES, WORDS_PER_BLOCK)-1:0] fill_tag,
  input  logic                                     dirty_en
);

  localparam int unsigned TAG_W = tag_w(LINES, WORDS_PER_BLOCK);

  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;

  // Lookup of the addressed line: hit test and victim description.
  always_comb begin
    victim_valid = valid_q[lk_index];
    victim_dirty = dirty_q[lk_index];
    victim_tag   = tag_q[lk_index];
    hit          = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
  end

  // Next state: a fill installs a clean valid line, a store marks it dirty.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) begin
      tag_d[lk_index]   = fill_tag;
      valid_d[lk_index] = 1'b1;
      dirty_d[lk_index] = 1'b0;
    end
    if (dirty_en) begin
      dirty_d[lk_index] = 1'b1;
    end
  end

  // Valid/dirty are reset; tags are left as they are.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag storage, no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

endmodule

// File: rtl/cache_l1_wb.sv
// Direct-mapped write-back / write-allocate L1 data cache with mem_ready handshake.
module cache_l1_wb
  import cache_pkg::*;
#(
  parameter int unsigned LINES           = 8,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic        cpu_rw,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_hold,
  output logic        mem_ce,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        last_access_hit
);

  localparam int unsigned OFF   = off_w(WORDS_PER_BLOCK);
  localparam int unsigned IX_W  = ix_w(LINES);
  localparam int unsigned TAG_W = tag_w(LINES, WORDS_PER_BLOCK);
  localparam int unsigned CNT_W = OFF - 2;

  logic [CNT_W-1:0] a_word;
  logic [IX_W-1:0]  a_index;
  logic [TAG_W-1:0] a_tag;
  logic             unused_byte_bits;

  assign a_word           = cpu_addr[OFF-1:2];
  assign a_index          = cpu_addr[OFF+IX_W-1:OFF];
  assign a_tag            = cpu_addr[31:OFF+IX_W];
  assign unused_byte_bits = ^cpu_addr[1:0];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic [IX_W-1:0]  req_index_q, req_index_d;
  logic [CNT_W-1:0] req_word_q, req_word_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             lah_q, lah_d;
  logic [31:0]      data_q [LINES][WORDS_PER_BLOCK];
  logic [31:0]      data_d [LINES][WORDS_PER_BLOCK];

  logic             data_we;
  logic [IX_W-1:0]  wr_index;
  logic [CNT_W-1:0] wr_word;
  logic [31:0]      wr_val;

  logic [IX_W-1:0]  lk_index;
  logic             hit, victim_valid, victim_dirty;
  logic [TAG_W-1:0] victim_tag;
  logic             fill_en, dirty_en;

  // Outside IDLE the tag store is steered to the latched request line.
  assign lk_index = (state_q == IDLE) ? a_index : req_index_q;

  cache_tag_store #(
    .LINES           (LINES),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_tags (
    .clk          (clk),
    .rst          (rst),
    .lk_index     (lk_index),
    .lk_tag       (a_tag),
    .hit          (hit),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .fill_en      (fill_en),
    .fill_tag     (req_tag_q),
    .dirty_en     (dirty_en)
  );

  // FSM next state, memory port, CPU stall and the single data-array write port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_tag_d   = req_tag_q;
    req_index_d = req_index_q;
    req_word_d  = req_word_q;
    rdata_d     = rdata_q;
    lah_d       = lah_q;
    cpu_hold    = 1'b0;
    mem_ce      = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_en     = 1'b0;
    dirty_en    = 1'b0;
    data_we     = 1'b0;
    wr_index    = req_index_q;
    wr_word     = req_word_q;
    wr_val      = cpu_wdata;
    case (state_q)
      IDLE: begin
        if (cpu_ce) begin
          if (hit) begin
            lah_d = 1'b1;
            if (cpu_rw) begin
              rdata_d = data_q[a_index][a_word];
            end else begin
              data_we  = 1'b1;
              wr_index = a_index;
              wr_word  = a_word;
              dirty_en = 1'b1;
            end
          end else begin
            cpu_hold    = 1'b1;
            lah_d       = 1'b0;
            req_tag_d   = a_tag;
            req_index_d = a_index;
            req_word_d  = a_word;
            cnt_d       = '0;
            state_d     = (victim_valid && victim_dirty) ? WB : FILL;
          end
        end
      end
      WB: begin
        cpu_hold  = 1'b1;
        mem_ce    = 1'b1;
        mem_rw    = 1'b0;
        mem_addr  = {victim_tag, req_index_q, cnt_q, 2'b00};
        mem_wdata = data_q[req_index_q][cnt_q];
        if (mem_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '1) begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        cpu_hold = 1'b1;
        mem_ce   = 1'b1;
        mem_rw   = 1'b1;
        mem_addr = {req_tag_q, req_index_q, cnt_q, 2'b00};
        if (mem_ready) begin
          data_we = 1'b1;
          wr_word = cnt_q;
          wr_val  = mem_rdata;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == '1) begin
            cnt_d   = '0;
            fill_en = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Serviced as a hit on the latched line; last_access_hit stays 0.
        if (cpu_rw) begin
          rdata_d = data_q[req_index_q][req_word_q];
        end else begin
          data_we  = 1'b1;
          dirty_en = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Data array next value from the single write port.
  always_comb begin
    data_d = data_q;
    if (data_we) begin
      data_d[wr_index][wr_word] = wr_val;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      lah_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      lah_q   <= lah_d;
    end
  end

  // Request latch and data array, not reset.
  always_ff @(posedge clk) begin
    req_tag_q   <= req_tag_d;
    req_index_q <= req_index_d;
    req_word_q  <= req_word_d;
    data_q      <= data_d;
  end

  assign cpu_rdata       = rdata_q;
  assign last_access_hit = lah_q;

endmodule

// File: tb/tb_cache_l1_wb.sv
// Self-checking bench for cache_l1_wb: directed plan plus randomized traffic
// checked against a line-level behavioural cache model.
module tb_cache_l1_wb;

  localparam int unsigned LINES = 8;
  localparam int unsigned W     = 8;
  localparam int unsigned BLK_B = W * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_ce = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_hold;
  logic        mem_ce;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b1;
  logic        last_access_hit;

  cache_l1_wb #(
    .LINES           (LINES),
    .WORDS_PER_BLOCK (W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_ce          (cpu_ce),
    .cpu_rw          (cpu_rw),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_hold        (cpu_hold),
    .mem_ce          (mem_ce),
    .mem_rw          (mem_rw),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ready       (mem_ready),
    .last_access_hit (last_access_hit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] m_mem   [logic [31:0]];

  int          rd_xfers   = 0;
  int          stalls     = 0;
  int          mem_cycles = 0;
  bit          rand_ready = 1'b0;
  int          stall_at   = -1;
  int          stall_left = 0;
  logic [31:0] stall_addr = '0;

  logic [31:0] m_tag   [LINES];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  logic [31:0] m_data  [LINES][W];
  logic [31:0] m_rdata;
  bit          m_lah;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Memory bus monitor: records completed words, counts stalls, checks hold-stability.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_rw;
  always @(posedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && mem_ce) begin
        chk("stall_hold_addr", mem_addr, prev_addr);
        chk("stall_hold_rw", {31'b0, mem_rw}, {31'b0, prev_rw});
        chk("stall_hold_wdata", mem_wdata, prev_wdata);
      end
      prev_stall = mem_ce && !mem_ready;
      prev_addr  = mem_addr;
      prev_rw    = mem_rw;
      prev_wdata = mem_wdata;
      if (mem_ce) begin
        mem_cycles++;
        if (mem_ready) begin
          txn_t t;
          t.rw = mem_rw; t.addr = mem_addr; t.data = mem_wdata;
          obs_q.push_back(t);
          if (mem_rw) rd_xfers++;
          else env_mem[mem_addr] = mem_wdata;
        end else begin
          stalls++;
        end
      end
    end
  end

  // Memory responder: mem[a] = a unless written; ready random, forced, or 1.
  always @(negedge clk) begin
    mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : mem_addr;
    if (mem_ce && mem_rw && stall_left > 0 && rd_xfers == stall_at) begin
      mem_ready = 1'b0;
      stall_left--;
      chk("stall_addr", mem_addr, stall_addr);
    end else if (rand_ready) begin
      mem_ready = ($urandom_range(0, 3) != 0);
    end else begin
      mem_ready = 1'b1;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < int'(LINES); i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_rdata = '0;
    m_lah   = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : a;
  endfunction

  // Whole-access model: predicts hit, write-back traffic, fill traffic and result.
  task automatic model_access(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                              output bit hit, output bit wb);
    int unsigned idx  = (addr / BLK_B) % LINES;
    int unsigned word = (addr / 4) % W;
    logic [31:0] tag  = addr / (BLK_B * LINES);
    logic [31:0] a;
    txn_t        t;
    exp_q.delete();
    hit = m_valid[idx] && (m_tag[idx] == tag);
    wb  = 1'b0;
    if (!hit) begin
      wb = m_valid[idx] && m_dirty[idx];
      if (wb) begin
        for (int w = 0; w < int'(W); w++) begin
          a = m_tag[idx] * (BLK_B * LINES) + idx * BLK_B + w * 4;
          t.rw = 1'b0; t.addr = a; t.data = m_data[idx][w];
          exp_q.push_back(t);
          m_mem[a] = m_data[idx][w];
        end
      end
      for (int w = 0; w < int'(W); w++) begin
        a = tag * (BLK_B * LINES) + idx * BLK_B + w * 4;
        t.rw = 1'b1; t.addr = a; t.data = '0;
        exp_q.push_back(t);
        m_data[idx][w] = m_read(a);
      end
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    if (rw) begin
      m_rdata = m_data[idx][word];
    end else begin
      m_data[idx][word] = wd;
      m_dirty[idx]      = 1'b1;
    end
    m_lah = hit;
  endtask

  task automatic access(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                        input string name);
    bit hit, wb;
    int hold, exp_hold, n;
    model_access(rw, addr, wd, hit, wb);
    obs_q.delete();
    rd_xfers   = 0;
    stalls     = 0;
    mem_cycles = 0;
    @(negedge clk);
    cpu_ce = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
    #1;
    hold = 0;
    while (cpu_hold === 1'b1 && hold < 500) begin
      hold++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    cpu_ce = 1'b0;
    #1;
    exp_hold = hit ? 0 : 1 + int'(W) + (wb ? int'(W) : 0) + stalls;
    chk({name, "_hold_cycles"}, 32'(hold), 32'(exp_hold));
    chk({name, "_mem_cycles"}, 32'(mem_cycles),
        32'(hit ? 0 : int'(W) * (wb ? 2 : 1) + stalls));
    chk({name, "_rdata"}, cpu_rdata, m_rdata);
    chk({name, "_last_hit"}, {31'b0, last_access_hit}, {31'b0, m_lah});
    chk({name, "_txn_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_txn_rw"}, {31'b0, obs_q[i].rw}, {31'b0, exp_q[i].rw});
      chk({name, "_txn_addr"}, obs_q[i].addr, exp_q[i].addr);
      if (!exp_q[i].rw) chk({name, "_txn_wdata"}, obs_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    int g;
    logic [31:0] ra;
    bit rrw;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("reset_rdata", cpu_rdata, 32'h0);
    chk("reset_last_hit", {31'b0, last_access_hit}, 32'h0);
    chk("reset_hold", {31'b0, cpu_hold}, 32'h0);
    chk("reset_mem_ce", {31'b0, mem_ce}, 32'h0);

    // Clean miss then hit on the same word
    access(1'b1, 32'h0000_0104, 32'h0, "rd_miss");
    chk("rd_miss_value", cpu_rdata, 32'h0000_0104);
    access(1'b1, 32'h0000_0104, 32'h0, "rd_hit");
    chk("rd_hit_flag", {31'b0, last_access_hit}, 32'h1);

    // Write hit, then dirty eviction by same-index read
    access(1'b0, 32'h0000_0104, 32'hDEAD_BEEF, "wr_hit");
    access(1'b1, 32'h0000_0904, 32'h0, "dirty_miss");
    chk("dirty_miss_value", cpu_rdata, 32'h0000_0904);
    chk("dirty_miss_wb_word", env_mem.exists(32'h104) ? env_mem[32'h104] : 32'h0,
        32'hDEAD_BEEF);

    // Write-allocate miss, then read back the merged word
    access(1'b0, 32'h0000_2008, 32'h1234_5678, "wr_miss");
    access(1'b1, 32'h0000_2008, 32'h0, "wr_miss_rd");
    chk("wr_miss_rd_value", cpu_rdata, 32'h1234_5678);

    // Idle with cpu_ce low holds outputs
    repeat (3) @(negedge clk);
    #1;
    chk("idle_rdata", cpu_rdata, 32'h1234_5678);
    chk("idle_last_hit", {31'b0, last_access_hit}, 32'h1);

    // mem_ready low for 3 cycles on the 4th fill word
    stall_at   = 3;
    stall_left = 3;
    stall_addr = 32'h0000_010C;
    access(1'b1, 32'h0000_0100, 32'h0, "stall");
    chk("stall_count", 32'(stalls), 32'd3);
    chk("stall_consumed", 32'(stall_left), 32'd0);
    stall_at = -1;

    // Randomized traffic with random memory wait states
    rand_ready = 1'b1;
    repeat (80) begin
      ra  = $urandom_range(0, 3) * (BLK_B * LINES) + $urandom_range(0, LINES - 1) * BLK_B
          + $urandom_range(0, W - 1) * 4 + $urandom_range(0, 3);
      rrw = $urandom_range(0, 1);
      access(rrw, ra, $urandom, "rand");
    end
    rand_ready = 1'b0;

    // Reset during the 5th fill word
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    rd_xfers = 0;
    @(negedge clk);
    cpu_ce = 1'b1; cpu_rw = 1'b1; cpu_addr = 32'h0000_0344;
    g = 0;
    while (rd_xfers < 4 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("rst_fill_reached", 32'(rd_xfers), 32'd4);
    rst = 1'b1;
    cpu_ce = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_mem_ce", {31'b0, mem_ce}, 32'h0);
    chk("rst_mid_hold", {31'b0, cpu_hold}, 32'h0);
    chk("rst_mid_rdata", cpu_rdata, 32'h0);
    access(1'b1, 32'h0000_0344, 32'h0, "post_rst");
    chk("post_rst_miss_flag", {31'b0, last_access_hit}, 32'h0);
    access(1'b1, 32'h0000_0904, 32'h0, "post_rst_other");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_l1_wb.md
# cache_l1_wb

Parametrised direct-mapped L1 data cache, successor to the 8-line write-through cache. Adds write-back/write-allocate with per-line dirty bits, configurable line count and block size, and a `mem_ready` handshake for variable-latency memory. Sits between the CPU load/store port and main memory. Uses separate read and write data buses in place of tristates.

## Interface
- `LINES`, default 8: number of lines; power of 2, at least 2.
- `WORDS_PER_BLOCK`, default 8: 32-bit words per block; power of 2, at least 2.
- `clk` in 1: clock, all logic on the rising edge. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_ce` in 1: access request.
- `cpu_rw` in 1: 1 = read, 0 = write.
- `cpu_addr` in 32: byte address. Bits [1:0] are ignored.
- `cpu_wdata` in 32: write data.
- `cpu_rdata` out 32: read data, registered.
- `cpu_hold` out 1: combinational stall. While it is high, the CPU keeps `cpu_ce`, `cpu_rw`, `cpu_addr` and `cpu_wdata` stable.
- `mem_ce` out 1: memory request.
- `mem_rw` out 1: 1 = read, 0 = write.
- `mem_addr` out 32: word-aligned byte address.
- `mem_wdata` out 32: write data to memory.
- `mem_rdata` in 32: read data, sampled at the edge where `mem_ready` is high.
- `mem_ready` in 1: the current memory word completes at this edge.
- `last_access_hit` out 1: debug; result of the most recent lookup.

## Operation
- **Address fields**
  - OFF = log2(WORDS_PER_BLOCK) + 2.
  - IX = log2(LINES).
  - word = addr[OFF-1:2], index = addr[OFF+IX-1:OFF], tag = addr[31:OFF+IX].
- **Storage**
  - Data array of LINES×WORDS_PER_BLOCK words.
  - Per line: a tag, a valid bit and a dirty bit.
- **Hit test:** hit = valid[index] && tag match. Evaluated only in IDLE.
- **IDLE**
  - Read hit: `cpu_rdata` ← word; `last_access_hit` ← 1.
  - Write hit: update the word; dirty[index] ← 1; `last_access_hit` ← 1. No memory access.
  - Miss (read or write):
    - `cpu_hold` = 1 in the same cycle; `last_access_hit` ← 0.
    - Latch the request tag, index and word.
    - Next state is WB if the line is valid and dirty, otherwise FILL. The counter is cleared.
- **WB**
  - `mem_ce`=1, `mem_rw`=0.
  - `mem_addr` = {victim tag, index, cnt, 2'b00}; `mem_wdata` = data[index][cnt].
  - On `mem_ready`: cnt+1. After the last word: cnt←0, go to FILL.
- **FILL**
  - `mem_ce`=1, `mem_rw`=1.
  - `mem_addr` = {req tag, index, cnt, 2'b00}.
  - On `mem_ready`: data[index][cnt] ← `mem_rdata`; cnt+1.
  - After the last word: tag ← req tag, valid ← 1, dirty ← 0, go to DONE.
- **DONE**
  - `cpu_hold`=0. The request is serviced as a hit, by the same rules as IDLE.
  - A write merges the CPU word and sets dirty.
  - `last_access_hit` is not changed; it stays 0.
  - Return to IDLE.
- **Outputs by state**
  - `cpu_hold` = 1 in WB and FILL, and in IDLE when `cpu_ce` && !hit. It is 0 otherwise.
  - `mem_ce` is 0 outside WB and FILL.
  - `mem_addr`, `mem_rw` and `mem_wdata` are held stable until `mem_ready`.
- **Boundary conditions**
  - `mem_ready` held low: stay in the current state with outputs unchanged, for any number of cycles.
  - Counter wrap at WORDS_PER_BLOCK-1 ends the phase; the counter never indexes past the block.
  - Miss with the victim valid but clean: skip WB.
  - Miss with the victim invalid: skip WB.
  - `cpu_ce`=0 in IDLE: no state change; `cpu_rdata` and `last_access_hit` hold.
- **Reset**
  - All valid and dirty bits ← 0.
  - state ← IDLE, cnt ← 0.
  - `cpu_rdata` ← 0, `last_access_hit` ← 0.
  - Data array and tags are not cleared.
- **Reset mid-WB/FILL:** abort. Dirty data in the cache is lost, a partial block stays invalid, and `mem_ce`=0 from the next cycle.

## Timing
- Read hit at cycle t: `cpu_rdata` valid from t+1; no stall.
- Write hit: completes at the edge ending cycle t.
- Clean miss at t, with `mem_ready`=1 throughout:
  - `cpu_hold` high in cycles t..t+W, where W = WORDS_PER_BLOCK.
  - DONE is cycle t+W+1; `cpu_rdata` valid at t+W+2.
- Dirty miss: adds W cycles to the clean-miss figures.
- Each `mem_ready`-low cycle adds one cycle.

## Structure
- Package `cache_pkg`:
  - State encoding: IDLE, WB, FILL, DONE.
  - Field-width helper functions for OFF, IX and the tag width, from LINES and WORDS_PER_BLOCK.
- Sub-module `cache_tag_store`: tag, valid and dirty arrays with a combinational hit/victim lookup and a synchronous update port.
- The top module holds the FSM, the counter and the data array.

## Test plan
Defaults; memory model returns mem[a] = a and has `mem_ready`=1 unless stated otherwise.
- After reset, read 0x0000_0104:
  - `cpu_hold` high for 9 cycles; 8 memory reads at 0x100..0x11C.
  - `cpu_rdata` = 0x104; `last_access_hit`=0.
  - Re-reading 0x0000_0104 is a hit: data next cycle, no hold, `last_access_hit`=1.
- Write 0xDEAD_BEEF to 0x104 (hit):
  - No `mem_ce`; dirty set.
  - Read 0x0000_0904 (same index, tag 0x09): 8 writes at 0x100..0x11C carrying the line, including 0xDEADBEEF at 0x104. Then 8 reads at 0x900..0x91C; `cpu_rdata` = 0x904.
- Write miss to 0x0000_2008 with data 0x1234_5678:
  - Line 0 is filled from 0x2000..0x201C; the word is merged and the line is dirty.
  - A following read of 0x2008 hits and returns 0x1234_5678.
- `mem_ready` low for 3 cycles on the 4th fill word: `mem_addr` holds at 0x10C, and the miss lasts 3 cycles longer.
- `rst` asserted during the 5th FILL word:
  - Next cycle: `mem_ce`=0, `cpu_hold`=0, and every line is invalid.
  - The same read then misses again.
